// File: rtl/input_conditioner.sv
// Two-player button conditioner: synchronizes, debounces and masks opposing
// directions on 14 raw buttons, then emits one-cycle press pulses.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] p1_raw,
  input  logic [6:0] p2_raw,
  output logic [6:0] p1_inputs,
  output logic [6:0] p2_inputs,
  output logic [6:0] p1_press,
  output logic [6:0] p2_press
);

  localparam int N  = 14;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         rst_sync;
  logic               core_rst_n;
  logic [N-1:0]       raw, sync0, sync1;
  logic [N-1:0]       deb, deb_next;
  logic [N-1:0][CW-1:0] cnt, cnt_next;
  logic [N-1:0]       inputs_q, inputs_next, press_q;

  // Left and right, and up and down, cancel each other while both are held.
  function automatic logic [6:0] exclude_opposing(input logic [6:0] d);
    logic [6:0] r;
    r    = d;
    r[1] = d[1] & ~d[2];
    r[2] = d[2] & ~d[1];
    r[3] = d[3] & ~d[4];
    r[4] = d[4] & ~d[3];
    return r;
  endfunction

  assign raw = {p2_raw, p1_raw};

  // NOTE: the data synchronizer leaves reset as soon as the pin releases, while
  // the debounce core waits two more edges; the two-edge synchronizer latency
  // hides that wait, so a held button still lands 2 + DEBOUNCE_CYCLES edges on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign core_rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
    end
  end

  always_comb begin
    deb_next = deb;
    cnt_next = '0;
    for (int i = 0; i < N; i++) begin
      if (sync1[i] != deb[i]) begin
        if (cnt[i] == CNT_MAX) deb_next[i] = sync1[i];
        else                   cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  // Outputs are registered from the next debounced value so they move on the
  // same edge as deb rather than one cycle later.
  assign inputs_next = {exclude_opposing(deb_next[13:7]),
                        exclude_opposing(deb_next[6:0])};

  // NOTE: every sequential assignment is non-blocking so all flops sample
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      deb      <= '0;
      cnt      <= '0;
      inputs_q <= '0;
      press_q  <= '0;
    end else begin
      deb      <= deb_next;
      cnt      <= cnt_next;
      inputs_q <= inputs_next;
      press_q  <= inputs_next & ~inputs_q;
    end
  end

  assign p1_inputs = inputs_q[6:0];
  assign p2_inputs = inputs_q[13:7];
  assign p1_press  = press_q[6:0];
  assign p2_press  = press_q[13:7];

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000, SHALL be the number of consecutive stable clk cycles required to accept a level change (legal range >= 2).
REQ-003 Port clk, input, 1 bit: the system clock; all state SHALL be updated on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port p1_raw, input, 7 bits: asynchronous raw buttons for player 1, bit map [0] center, [1] left, [2] right, [3] up, [4] down, [5] attack, [6] shield; 1 = pressed.
REQ-006 Port p2_raw, input, 7 bits: same as p1_raw, for player 2.
REQ-007 Port p1_inputs, output, 7 bits, registered: conditioned button levels for player 1, with the same bit map; this port drives the game block's p1_inputs.
REQ-008 Port p2_inputs, output, 7 bits, registered: same as p1_inputs, for player 2.
REQ-009 Port p1_press, output, 7 bits, registered: one-cycle press pulses for player 1, with the same bit map.
REQ-010 Port p2_press, output, 7 bits, registered: same as p1_press, for player 2.

Function
REQ-011 Each of the 14 raw bits SHALL pass through an independent two-flip-flop synchronizer before any other logic uses it.
REQ-012 Each bit SHALL hold a debounced level (deb) and a mismatch counter; the counter SHALL be wide enough to hold DEBOUNCE_CYCLES-1 without wrapping.
REQ-013 When the synchronized value equals deb, that bit's counter SHALL clear to 0 on the next edge.
REQ-014 When the synchronized value differs from deb and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 When the synchronized value differs from deb and the counter equals DEBOUNCE_CYCLES-1, deb SHALL take the synchronized value and the counter SHALL clear, both on the same edge.
REQ-016 A held raw change SHALL therefore appear on deb exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-017 Any pulse shorter than DEBOUNCE_CYCLES cycles, as seen after synchronization, SHALL leave deb unchanged.
REQ-018 Opposing directions SHALL be mutually exclusive at the outputs:
- inputs[1] = deb[1] AND NOT deb[2]; inputs[2] = deb[2] AND NOT deb[1].
- inputs[3] = deb[3] AND NOT deb[4]; inputs[4] = deb[4] AND NOT deb[3].
REQ-019 Bits 0, 5 and 6 of the inputs outputs SHALL equal deb directly.
REQ-020 The inputs outputs SHALL update in the same cycle as the deb registers that feed them, adding no extra latency.
REQ-021 press[i] SHALL be 1 for exactly one cycle: the first cycle in which inputs[i] reads 1 after having read 0.
REQ-022 A direction that becomes 1 only because its opposite was released SHALL also generate a press pulse.
REQ-023 A press pulse SHALL never repeat while its button stays held; release and re-press SHALL produce a new pulse.
REQ-024 Simultaneous events on several bits or both players SHALL be processed independently in the same cycle, with no priority and no interaction beyond REQ-018.

Reset
REQ-025 While reset = 0, the following SHALL be 0 immediately and asynchronously:
- all synchronizer flip-flops, deb registers and counters;
- p1_inputs, p2_inputs, p1_press and p2_press.
REQ-026 Reset asserted mid-count SHALL discard any partial count.
REQ-027 After reset deasserts with a button already held, that button SHALL be treated as a new press: inputs and press rise 2 + DEBOUNCE_CYCLES edges after the first post-reset edge.
REQ-028 Reset deassertion SHALL be synchronized internally to clk (assert asynchronously, release synchronously).

Verification (DEBOUNCE_CYCLES = 4)
REQ-029 Reset with all raw inputs at 0 -> all outputs 0 during reset and for 10 cycles after release.
REQ-030 Set p1_raw[5] = 1 and hold -> p1_inputs[5] rises on edge 6 after the change; p1_press[5] is high for only that cycle; no further pulse over the next 20 cycles.
REQ-031 Set p2_raw[0] = 1 for 3 cycles, then 0 -> p2_inputs[0] and p2_press[0] stay 0 throughout.
REQ-032 Hold p1_raw[1] and p1_raw[2] together -> p1_inputs[2:1] = 00 with no press pulses; release p1_raw[2] -> p1_inputs[1] = 1 with a one-cycle p1_press[1] exactly 6 edges later.
REQ-033 Hold p2_raw[6], let p2_inputs[6] = 1, then pulse reset low for 1 cycle -> p2_inputs[6] = 0 at once; p2_inputs[6] and p2_press[6] rise again 6 edges after the first edge following release.
REQ-034 Toggle all 14 raw bits with independent random patterns, using stable periods of 1 to 8 cycles -> outputs match a cycle-accurate reference model on every cycle.
